xy2_tx_sched: RTL and testbench
===============================

// Module: xy2_tx_sched
// PURPOSE
//  Round-robin scheduler that shares one xy2_100 galvo transmitter among up to three scan generators.
//  - Each generator is a requester: send strobe plus 16-bit X/Y coordinate.
//  - The block holds one pending point per requester and issues one point at a time to the transmitter.
//  - A point is complete when txdone arrives, or when a watchdog expires.
//  - Sits between scan/scan2/scan3 and u_xy2_100; replaces the one-hot mux_scan path.
// PARAMETERS
//  NSRC      3       number of requesters (fixed at 3 in this revision)
//  TIMEOUT   4096    max cycles in WAIT_DONE before aborting the frame (>=2)
//  TW        13      width of the watchdog counter, clog2(TIMEOUT)+1
// PORTS
//  clk          in   1   system clock (50 MHz domain of xy2_100)
//  rst_n        in   1   synchronous active-low reset
//  src_en       in   3   requester enable (send_en/send_en2/send_en3); 0 flushes that pending slot
//  src_send     in   3   one-cycle strobe per requester: a new point is on src_x/src_y
//  src_x        in   48  {x_3,x_2,x_1} coordinates, 16 bits each
//  src_y        in   48  {y_3,y_2,y_1} coordinates, 16 bits each
//  tx_done      in   1   txdone from xy2_100, one-cycle pulse at end of frame
//  clr_err      in   1   clears the sticky error flags
//  tx_send      out  1   one-cycle start pulse to xy2_100 send_en
//  tx_x         out  16  X word to xy2_100; held stable from tx_send until frame end
//  tx_y         out  16  Y word to xy2_100; held stable from tx_send until frame end
//  grant        out  2   index of the requester in service (0..2); 3 = none
//  pending      out  3   per-requester slot-full flags
//  ovf_err      out  3   sticky: a point was overwritten before it was issued
//  tmo_err      out  1   sticky: watchdog expired waiting for tx_done
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge), also mid-frame:
//   - tx_send=0; tx_x=tx_y=0; grant=3; pending=0; ovf_err=0; tmo_err=0
//   - state=IDLE; round-robin pointer last=2, so requester 0 is checked first
//  Slot capture, per requester i, every cycle:
//   - src_en[i]=0: pending[i] goes to 0 next cycle; strobes from i are ignored.
//   - src_send[i]&src_en[i]: slot i loads src_x/src_y[16i+:16]; pending[i]=1 next cycle.
//   - Strobe while pending[i]=1 (and not being issued this cycle): newest point overwrites, ovf_err[i] set.
//   - Strobe in the same cycle slot i is issued: the new point is captured, pending[i] stays 1, no ovf_err.
//  FSM:
//   - IDLE: if any pending, choose the first pending index after 'last' (cyclic 0->1->2->0).
//     Load tx_x/tx_y from that slot, grant=idx, last=idx, clear pending[idx], go to ISSUE.
//     Decision and load happen in the same cycle; tx_send asserts on the next cycle.
//   - ISSUE: tx_send=1 for exactly one cycle; clear the watchdog; go to WAIT_DONE.
//   - WAIT_DONE: tx_send=0; count cycles.
//     tx_done=1 -> IDLE, grant=3.
//     Count reaches TIMEOUT-1 without tx_done -> tmo_err=1, IDLE, grant=3.
//     tx_done is ignored in every state other than WAIT_DONE.
//  Timing and arithmetic:
//   - Latency: strobe at cycle n into an idle scheduler -> pending at n+1 -> tx_send at n+2.
//   - Back-to-back: tx_done at cycle m -> next tx_send at m+2 at the earliest.
//   - tx_x/tx_y change only in the IDLE->ISSUE load cycle.
//   - The watchdog saturates; no wrap.
//  Error flags:
//   - clr_err clears ovf_err and tmo_err.
//   - An error event in the same cycle as clr_err wins: the flag stays set.
//  Requester disabled mid-service:
//   - The current frame still completes; the fresh slot capture/flush rules apply afterwards.
// TESTING
//  T1 reset: rst_n=0 mid-WAIT_DONE -> next cycle tx_send=0, grant=3, pending=0, errors=0, tx_x=tx_y=0.
//  T2 single source: src_en=001, src_send[0] at n with x=0x1234,y=0xABCD ->
//     tx_send at n+2 with tx_x=0x1234, tx_y=0xABCD, grant=0; after tx_done, grant=3.
//  T3 round-robin: all three pending at once, tx_done 10 cycles after each tx_send ->
//     grant sequence 0,1,2; re-pend all three -> 0,1,2 again; no requester starved.
//  T4 overflow: two strobes from source 1 (0x0001 then 0x0002) while busy on 0 ->
//     ovf_err=010; the issued point is 0x0002. clr_err -> ovf_err=000.
//  T5 timeout: TIMEOUT=16, tx_done held 0 ->
//     tmo_err=1 exactly 16 cycles after tx_send; FSM back in IDLE; next pending point is issued.
//  T6 flush/edge: src_en[2] dropped while pending[2]=1 -> pending[2]=0, never granted;
//     strobe in the slot's issue cycle -> captured, pending stays 1, no ovf_err.

Source files
------------

// File: rtl/xy2_tx_sched.sv
`default_nettype none
// ==========================================================================
// xy2_tx_sched : round-robin scheduler sharing one xy2_100 transmitter
//                among up to three scan generators, with watchdog.
// Rev 1.0
// ==========================================================================
module xy2_tx_sched #(
  parameter int NSRC    = 3,
  parameter int TIMEOUT = 4096,
  parameter int TW      = 13
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NSRC-1:0]    src_en,
  input  logic [NSRC-1:0]    src_send,
  input  logic [16*NSRC-1:0] src_x,
  input  logic [16*NSRC-1:0] src_y,
  input  logic               tx_done,
  input  logic               clr_err,
  output logic               tx_send,
  output logic [15:0]        tx_x,
  output logic [15:0]        tx_y,
  output logic [1:0]         grant,
  output logic [NSRC-1:0]    pending,
  output logic [NSRC-1:0]    ovf_err,
  output logic               tmo_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam logic [1:0]    NO_GRANT = 2'd3;
  localparam logic [TW-1:0] WD_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] WD_MAX   = {TW{1'b1}};

  state_t          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic [1:0]      last_q, last_d;
  logic [15:0]     tx_x_q, tx_x_d;
  logic [15:0]     tx_y_q, tx_y_d;
  logic [TW-1:0]   wdog_q, wdog_d;
  logic            tmo_q, tmo_d;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] ovf_q, ovf_d;
  logic [15:0]     slot_x_q [NSRC];
  logic [15:0]     slot_x_d [NSRC];
  logic [15:0]     slot_y_q [NSRC];
  logic [15:0]     slot_y_d [NSRC];

  logic [NSRC-1:0] req;
  logic [NSRC-1:0] issue_vec;
  logic [1:0]      cand1, cand2, cand3;
  logic [1:0]      sel_idx;
  logic            sel_found;
  logic [TW-1:0]   wdog_inc;

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // A slot being flushed this cycle is not eligible for issue.
  always_comb begin
    req       = pending_q & src_en;
    cand1     = rr_next(last_q);
    cand2     = rr_next(cand1);
    cand3     = rr_next(cand2);
    sel_found = |req;
    if (req[cand1])      sel_idx = cand1;
    else if (req[cand2]) sel_idx = cand2;
    else                 sel_idx = cand3;
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    tx_x_d    = tx_x_q;
    tx_y_d    = tx_y_q;
    wdog_d    = wdog_q;
    tmo_d     = tmo_q & ~clr_err;
    issue_vec = '0;
    wdog_inc  = (wdog_q == WD_MAX) ? wdog_q : wdog_q + TW'(1);
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          tx_x_d             = slot_x_q[sel_idx];
          tx_y_d             = slot_y_q[sel_idx];
          grant_d            = sel_idx;
          last_d             = sel_idx;
          issue_vec[sel_idx] = 1'b1;
          state_d            = ISSUE;
        end
      end
      ISSUE: begin
        wdog_d  = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done) begin
          grant_d = NO_GRANT;
          state_d = IDLE;
        end else begin
          wdog_d = wdog_inc;
          // Terminal count is judged on the incremented value so the error
          // flag lands TIMEOUT cycles after the start pulse.
          if (wdog_inc == WD_LAST) begin
            tmo_d   = 1'b1;
            grant_d = NO_GRANT;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pending_d = pending_q;
    ovf_d     = ovf_q & ~{NSRC{clr_err}};
    slot_x_d  = slot_x_q;
    slot_y_d  = slot_y_q;
    for (int i = 0; i < NSRC; i++) begin
      if (!src_en[i]) begin
        pending_d[i] = 1'b0;
      end else if (src_send[i]) begin
        slot_x_d[i]  = src_x[16*i +: 16];
        slot_y_d[i]  = src_y[16*i +: 16];
        pending_d[i] = 1'b1;
        if (pending_q[i] && !issue_vec[i]) ovf_d[i] = 1'b1;
      end else if (issue_vec[i]) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= NO_GRANT;
      last_q    <= 2'd2;
      tx_x_q    <= '0;
      tx_y_q    <= '0;
      wdog_q    <= '0;
      tmo_q     <= 1'b0;
      pending_q <= '0;
      ovf_q     <= '0;
      for (int i = 0; i < NSRC; i++) begin
        slot_x_q[i] <= '0;
        slot_y_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      tx_x_q    <= tx_x_d;
      tx_y_q    <= tx_y_d;
      wdog_q    <= wdog_d;
      tmo_q     <= tmo_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      slot_x_q  <= slot_x_d;
      slot_y_q  <= slot_y_d;
    end
  end

  assign tx_send = (state_q == ISSUE);
  assign tx_x    = tx_x_q;
  assign tx_y    = tx_y_q;
  assign grant   = grant_q;
  assign pending = pending_q;
  assign ovf_err = ovf_q;
  assign tmo_err = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_xy2_tx_sched.sv
`default_nettype none
// ==========================================================================
// tb_xy2_tx_sched : directed stimulus, per-cycle compare against a
//                   frame-level model plus hand-computed checkpoints.
// Rev 1.0
// ==========================================================================
module tb_xy2_tx_sched;

  localparam int TIMEOUT = 16;
  localparam int TW      = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  src_en;
  logic [2:0]  src_send;
  logic [47:0] src_x;
  logic [47:0] src_y;
  logic        tx_done;
  logic        clr_err;
  logic        tx_send;
  logic [15:0] tx_x;
  logic [15:0] tx_y;
  logic [1:0]  grant;
  logic [2:0]  pending;
  logic [2:0]  ovf_err;
  logic        tmo_err;

  always #5 clk = ~clk;

  xy2_tx_sched #(.NSRC(3), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .src_en(src_en), .src_send(src_send),
    .src_x(src_x), .src_y(src_y), .tx_done(tx_done), .clr_err(clr_err),
    .tx_send(tx_send), .tx_x(tx_x), .tx_y(tx_y), .grant(grant),
    .pending(pending), .ovf_err(ovf_err), .tmo_err(tmo_err)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: one frame owns the transmitter from its start cycle until done/timeout.
  logic [2:0]  m_pend = '0;
  logic [2:0]  m_ovf  = '0;
  logic        m_tmo  = 1'b0;
  int          m_grant = 3;
  int          m_last  = 2;
  int          m_sent_at = -1000;
  logic [15:0] m_txx = '0;
  logic [15:0] m_txy = '0;
  logic [15:0] m_sx [3];
  logic [15:0] m_sy [3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    logic [2:0] old_pend;
    int iss;
    int c;
    logic tmo_ev;
    old_pend = m_pend;
    iss = -1;
    tmo_ev = 1'b0;
    if (!rst_n) begin
      m_pend = '0; m_ovf = '0; m_tmo = 1'b0; m_grant = 3; m_last = 2;
      m_txx = '0; m_txy = '0; m_sent_at = -1000;
    end else begin
      if (m_grant == 3) begin
        for (int k = 1; k <= 3; k++) begin
          c = (m_last + k) % 3;
          if (iss < 0 && old_pend[c] && src_en[c]) iss = c;
        end
        if (iss >= 0) begin
          m_txx = m_sx[iss]; m_txy = m_sy[iss];
          m_grant = iss; m_last = iss; m_sent_at = cyc + 1;
        end
      end else if (cyc > m_sent_at) begin
        if (tx_done) m_grant = 3;
        else if (cyc - m_sent_at == TIMEOUT - 1) begin
          m_grant = 3; tmo_ev = 1'b1;
        end
      end
      m_tmo = (m_tmo && !clr_err) || tmo_ev;
      for (int i = 0; i < 3; i++) begin
        if (clr_err) m_ovf[i] = 1'b0;
        if (!src_en[i]) m_pend[i] = 1'b0;
        else if (src_send[i]) begin
          m_sx[i] = src_x[16*i +: 16];
          m_sy[i] = src_y[16*i +: 16];
          if (old_pend[i] && iss != i) m_ovf[i] = 1'b1;
          m_pend[i] = 1'b1;
        end else if (iss == i) m_pend[i] = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("tx_send", 32'(tx_send), 32'(m_sent_at == cyc));
    chk("tx_x", 32'(tx_x), 32'(m_txx));
    chk("tx_y", 32'(tx_y), 32'(m_txy));
    chk("grant", 32'(grant), 32'(m_grant));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
    chk("tmo_err", 32'(tmo_err), 32'(m_tmo));
  endtask

  task automatic strobe(input int i, input logic [15:0] x, input logic [15:0] y);
    src_send[i] = 1'b1;
    src_x[16*i +: 16] = x;
    src_y[16*i +: 16] = y;
    tick();
    src_send = '0;
  endtask

  task automatic wait_send();
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!tx_send && k < 60);
    chk("wait_send_bound", 32'(tx_send), 32'd1);
  endtask

  task automatic done_after(input int n);
    repeat (n) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [1:0]  gseq [6];
    logic [15:0] xseq [6];
    logic [1:0]  exp_g [6];
    logic [15:0] exp_x [6];
    exp_g = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    exp_x = '{16'h0A01, 16'h0B02, 16'h0C03, 16'h1A01, 16'h1B02, 16'h1C03};

    rst_n = 1'b0; src_en = '0; src_send = '0; src_x = '0; src_y = '0;
    tx_done = 1'b0; clr_err = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_grant", 32'(grant), 32'd3);
    chk("rst_pending", 32'(pending), 32'd0);

    // T2 single source
    src_en = 3'b001;
    strobe(0, 16'h1234, 16'hABCD);
    chk("t2_pend", 32'(pending), 32'd1);
    tick();
    chk("t2_send", 32'(tx_send), 32'd1);
    chk("t2_x", 32'(tx_x), 32'h1234);
    chk("t2_y", 32'(tx_y), 32'hABCD);
    chk("t2_grant", 32'(grant), 32'd0);
    done_after(9);
    chk("t2_release", 32'(grant), 32'd3);

    // T1 reset mid-frame with errors present
    strobe(0, 16'h5555, 16'h6666);
    tick(); tick(); tick();
    strobe(0, 16'h0001, 16'h0001);
    strobe(0, 16'h0002, 16'h0002);
    chk("t1_ovf_pre", 32'(ovf_err), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t1_send", 32'(tx_send), 32'd0);
    chk("t1_grant", 32'(grant), 32'd3);
    chk("t1_pend", 32'(pending), 32'd0);
    chk("t1_ovf", 32'(ovf_err), 32'd0);
    chk("t1_tmo", 32'(tmo_err), 32'd0);
    chk("t1_xy", 32'({tx_x, tx_y}), 32'd0);
    tick();

    // T3 round robin, two rounds
    src_en = 3'b111;
    src_send = 3'b111;
    src_x = {16'h0C03, 16'h0B02, 16'h0A01};
    src_y = {16'h3C03, 16'h3B02, 16'h3A01};
    tick();
    src_send = '0;
    for (int f = 0; f < 6; f++) begin
      if (f == 3) begin
        src_send = 3'b111;
        src_x = {16'h1C03, 16'h1B02, 16'h1A01};
        tick();
        src_send = '0;
      end
      wait_send();
      gseq[f] = grant;
      xseq[f] = tx_x;
      done_after(10);
    end
    for (int f = 0; f < 6; f++) begin
      chk("t3_grant_seq", 32'(gseq[f]), 32'(exp_g[f]));
      chk("t3_x_seq", 32'(xseq[f]), 32'(exp_x[f]));
    end

    // T4 overflow
    src_en = 3'b011;
    strobe(0, 16'h00A0, 16'h00B0);
    wait_send();
    chk("t4_grant0", 32'(grant), 32'd0);
    strobe(1, 16'h0001, 16'h0101);
    strobe(1, 16'h0002, 16'h0202);
    chk("t4_ovf", 32'(ovf_err), 32'b010);
    done_after(5);
    wait_send();
    chk("t4_grant1", 32'(grant), 32'd1);
    chk("t4_x", 32'(tx_x), 32'h0002);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t4_clr", 32'(ovf_err), 32'd0);
    done_after(3);

    // T5 watchdog
    src_en = 3'b001;
    strobe(0, 16'h7777, 16'h7070);
    wait_send();
    strobe(0, 16'h8888, 16'h8080);
    n = 1;
    while (!tmo_err && n < 40) begin
      tick();
      n++;
    end
    chk("t5_tmo_latency", 32'(n), 32'd16);
    chk("t5_grant", 32'(grant), 32'd3);
    tick();
    chk("t5_next_send", 32'(tx_send), 32'd1);
    chk("t5_next_x", 32'(tx_x), 32'h8888);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t5_clr", 32'(tmo_err), 32'd0);
    done_after(2);

    // T6 flush and issue-cycle capture
    src_en = 3'b111;
    strobe(0, 16'h00AA, 16'h00BB);
    wait_send();
    chk("t6_grant0", 32'(grant), 32'd0);
    strobe(2, 16'hCCCC, 16'hDDDD);
    chk("t6_pend2", 32'(pending), 32'b100);
    src_en = 3'b011;
    tick();
    chk("t6_flush", 32'(pending), 32'd0);
    strobe(1, 16'h1111, 16'h1212);
    tick(); tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    strobe(1, 16'h2222, 16'h2323);
    chk("t6_send", 32'(tx_send), 32'd1);
    chk("t6_x", 32'(tx_x), 32'h1111);
    chk("t6_grant1", 32'(grant), 32'd1);
    chk("t6_pend_kept", 32'(pending), 32'b010);
    chk("t6_no_ovf", 32'(ovf_err), 32'd0);
    done_after(4);
    wait_send();
    chk("t6_grant_again", 32'(grant), 32'd1);
    chk("t6_x2", 32'(tx_x), 32'h2222);
    done_after(2);
    tick(); tick(); tick();
    chk("t6_idle_grant", 32'(grant), 32'd3);
    chk("t6_idle_pend", 32'(pending), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
